mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-mapped responder: internal RAM, an output register and a free-running
// cycle counter behind a fixed-latency request/ready handshake.
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int WAIT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] memAddr,
  input  logic [15:0] memWrite,
  input  logic        memWE,
  input  logic        memReq,
  output logic [15:0] memRead,
  output logic        memReady,
  output logic [15:0] outPort
);

  localparam int unsigned RamWords = 1 << ADDR_BITS;
  localparam logic [15:0] AddrOut  = 16'hFFFF;
  localparam logic [15:0] AddrCyc  = 16'hFFFE;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e               stateQ, stateD;
  logic [3:0]           waitQ, waitD;
  logic [15:0]          addrQ, addrD;
  logic [15:0]          dataQ, dataD;
  logic                 weQ, weD;
  logic [15:0]          readQ, outQ, cycleQ;
  logic [15:0]          ram [0:RamWords-1];

  logic                 complete;
  logic [15:0]          accAddr, accData;
  logic                 accWe;
  logic                 hitOut, hitCyc, hitRam;
  logic [ADDR_BITS-1:0] ramIdx;
  logic [15:0]          readData;

  always_comb begin
    stateD   = stateQ;
    waitD    = waitQ;
    addrD    = addrQ;
    dataD    = dataQ;
    weD      = weQ;
    complete = 1'b0;
    case (stateQ)
      S_IDLE: begin
        if (memReq) begin
          addrD = memAddr;
          dataD = memWrite;
          weD   = memWE;
          if (WAIT == 0) begin
            stateD   = S_RESP;
            complete = 1'b1;
          end else begin
            stateD = S_WAIT;
            waitD  = 4'(WAIT);
          end
        end
      end
      S_WAIT: begin
        waitD = waitQ - 4'd1;
        if (waitQ == 4'd1) begin
          stateD   = S_RESP;
          complete = 1'b1;
        end
      end
      S_RESP:  stateD = S_IDLE;
      default: stateD = S_IDLE;
    endcase
  end

  // With WAIT=0 the access completes on the sampling edge, so use the live inputs
  assign accAddr = (stateQ == S_IDLE) ? memAddr  : addrQ;
  assign accData = (stateQ == S_IDLE) ? memWrite : dataQ;
  assign accWe   = (stateQ == S_IDLE) ? memWE    : weQ;

  assign hitOut = (accAddr == AddrOut);
  assign hitCyc = (accAddr == AddrCyc);
  assign hitRam = !hitOut && !hitCyc && (32'(accAddr) < RamWords);
  assign ramIdx = accAddr[ADDR_BITS-1:0];

  always_comb begin
    readData = 16'h0000;
    if (hitOut)      readData = outQ;
    else if (hitCyc) readData = cycleQ;
    else if (hitRam) readData = ram[ramIdx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= S_IDLE;
      waitQ  <= 4'd0;
      addrQ  <= 16'h0000;
      dataQ  <= 16'h0000;
      weQ    <= 1'b0;
      readQ  <= 16'h0000;
      outQ   <= 16'h0000;
      cycleQ <= 16'h0000;
    end else begin
      stateQ <= stateD;
      waitQ  <= waitD;
      addrQ  <= addrD;
      dataQ  <= dataD;
      weQ    <= weD;
      cycleQ <= cycleQ + 16'd1;
      if (complete && !accWe) readQ <= readData;
      if (complete && accWe && hitOut) outQ <= accData;
    end
  end

  // RAM is deliberately left out of reset so preloaded contents survive it
  always_ff @(posedge clk) begin
    if (complete && accWe && hitRam && !rst) ram[ramIdx] <= accData;
  end

  assign memReady = (stateQ == S_RESP);
  assign memRead  = readQ;
  assign outPort  = outQ;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, back-to-back and reset
// sequences, randomized accesses against a behavioural memory-map model.
module tb_mem_responder;

  localparam int WAITP = 2;

  logic        clk;
  logic        rst;
  logic [15:0] memAddr, memWrite, memRead, outPort;
  logic        memWE, memReq, memReady;
  logic [15:0] r0Addr, r0Write, r0Read, r0Out;
  logic        r0WE, r0Req, r0Ready;

  mem_responder #(.ADDR_BITS(8), .WAIT(WAITP)) dut (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memWrite(memWrite), .memWE(memWE),
    .memReq(memReq), .memRead(memRead), .memReady(memReady), .outPort(outPort)
  );

  mem_responder #(.ADDR_BITS(8), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .memAddr(r0Addr), .memWrite(r0Write), .memWE(r0WE),
    .memReq(r0Req), .memRead(r0Read), .memReady(r0Ready), .outPort(r0Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expRead;
    logic [15:0] expOut;
  } vec_t;

  vec_t        vecs[13];
  logic [15:0] randAddrs[12];
  logic [15:0] ramModel[256];
  logic [15:0] outModel, lastRead;
  time         relTime;
  int          testCount, failCount;
  logic [15:0] rd, op;
  logic [15:0] burstData[3];
  int          burstCyc[3];
  int          burstGot;
  int          seen;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Clock edges since reset release; the counter starts at 0 on the first one
  function automatic int edgesSinceRelease();
    return int'(($time - relTime) / 10);
  endfunction

  function automatic logic [15:0] predict(input logic [15:0] a, input int e);
    if (a == 16'hFFFF) return outModel;
    if (a == 16'hFFFE) return 16'(e + WAITP);
    if (a < 16'd256)   return ramModel[a[7:0]];
    return 16'h0000;
  endfunction

  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] data,
                               output logic [15:0] rdo, output logic [15:0] opo);
    int          lat;
    logic [15:0] expRd;
    expRd    = we ? lastRead : predict(addr, edgesSinceRelease());
    memWE    = we;
    memAddr  = addr;
    memWrite = data;
    memReq   = 1'b1;
    @(negedge clk);
    memReq   = 1'b0;
    memWE    = 1'($urandom);
    memAddr  = 16'($urandom);
    memWrite = 16'($urandom);
    lat = 1;
    while (!memReady && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdo = memRead;
    opo = outPort;
    if (we) begin
      if (addr == 16'hFFFF) outModel = data;
      else if (addr < 16'd256) ramModel[addr[7:0]] = data;
    end else begin
      lastRead = expRd;
    end
    checkOutput("latency", 16'(lat), 16'(WAITP + 1));
    checkOutput("readData", rdo, expRd);
    checkOutput("outPort", opo, outModel);
    @(negedge clk);
    checkOutput("readyWidth", {15'd0, memReady}, 16'd0);
  endtask

  task automatic applyStimulus0(input logic we, input logic [15:0] addr, input logic [15:0] data,
                                input logic [15:0] expRd, input logic [15:0] expOp);
    r0WE    = we;
    r0Addr  = addr;
    r0Write = data;
    r0Req   = 1'b1;
    @(negedge clk);
    r0Req = 1'b0;
    checkOutput("w0.ready", {15'd0, r0Ready}, 16'd1);
    checkOutput("w0.read", r0Read, expRd);
    checkOutput("w0.out", r0Out, expOp);
    @(negedge clk);
    checkOutput("w0.readyWidth", {15'd0, r0Ready}, 16'd0);
  endtask

  // memReq stays high; the address advances each time a response is seen
  task automatic burst(input int n, input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
    logic [15:0] addrs[3];
    int          t;
    addrs[0] = a0;
    addrs[1] = a1;
    addrs[2] = a2;
    burstGot = 0;
    t = 0;
    memWE   = 1'b0;
    memAddr = addrs[0];
    memReq  = 1'b1;
    while (burstGot < n && t < 60) begin
      @(negedge clk);
      t++;
      if (memReady) begin
        burstData[burstGot] = memRead;
        burstCyc[burstGot]  = t;
        burstGot++;
        if (burstGot < 3) memAddr = addrs[burstGot];
      end
    end
    memReq = 1'b0;
    checkOutput("burstCount", 16'(burstGot), 16'(n));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testCount = 0;
    failCount = 0;
    outModel  = 16'h0000;
    lastRead  = 16'h0000;
    relTime   = 0;
    rst = 1'b0;
    memReq = 1'b0; memWE = 1'b0; memAddr = 16'h0; memWrite = 16'h0;
    r0Req = 1'b0; r0WE = 1'b0; r0Addr = 16'h0; r0Write = 16'h0;
    foreach (ramModel[i]) ramModel[i] = 16'h0000;

    vecs[0]  = '{1'b1, 16'h0010, 16'h1234, 16'h000B, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 16'h0000};
    vecs[2]  = '{1'b1, 16'hFFFF, 16'hBEEF, 16'h1234, 16'hBEEF};
    vecs[3]  = '{1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[4]  = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[5]  = '{1'b1, 16'h0000, 16'h0042, 16'h0000, 16'hBEEF};
    vecs[6]  = '{1'b1, 16'h0100, 16'h9999, 16'h0000, 16'hBEEF};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h0042, 16'hBEEF};
    vecs[8]  = '{1'b1, 16'hFFFE, 16'h7777, 16'h0042, 16'hBEEF};
    vecs[9]  = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 16'hBEEF};
    vecs[10] = '{1'b1, 16'h00FF, 16'hABCD, 16'h1234, 16'hBEEF};
    vecs[11] = '{1'b0, 16'h00FF, 16'h0000, 16'hABCD, 16'hBEEF};
    vecs[12] = '{1'b0, 16'h1234, 16'h0000, 16'h0000, 16'hBEEF};

    randAddrs = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                  16'h0006, 16'h0007, 16'hFFFE, 16'hFFFF, 16'h0300, 16'h8000};

    #1 rst = 1'b1;
    #2;
    checkOutput("reset.ready", {15'd0, memReady}, 16'd0);
    checkOutput("reset.read", memRead, 16'h0000);
    checkOutput("reset.out", outPort, 16'h0000);
    checkOutput("reset0.ready", {15'd0, r0Ready}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    relTime = $time;

    repeat (5) @(negedge clk);
    burst(2, 16'hFFFE, 16'hFFFE, 16'hFFFE);
    checkOutput("cycle.first", burstData[0], 16'h0007);
    checkOutput("cycle.second", burstData[1], 16'h000B);
    checkOutput("cycle.latency", 16'(burstCyc[0]), 16'(WAITP + 1));
    lastRead = 16'h000B;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, op);
      checkOutput($sformatf("vec%0d.read", i), rd, vecs[i].expRead);
      checkOutput($sformatf("vec%0d.out", i), op, vecs[i].expOut);
    end

    applyStimulus(1'b1, 16'h0000, 16'h000A, rd, op);
    applyStimulus(1'b1, 16'h0001, 16'h000B, rd, op);
    applyStimulus(1'b1, 16'h0002, 16'h000C, rd, op);
    burst(3, 16'h0000, 16'h0001, 16'h0002);
    checkOutput("b2b.d0", burstData[0], 16'h000A);
    checkOutput("b2b.d1", burstData[1], 16'h000B);
    checkOutput("b2b.d2", burstData[2], 16'h000C);
    checkOutput("b2b.gap1", 16'(burstCyc[1] - burstCyc[0]), 16'(WAITP + 2));
    checkOutput("b2b.gap2", 16'(burstCyc[2] - burstCyc[1]), 16'(WAITP + 2));
    lastRead = 16'h000C;

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(i), 16'($urandom), rd, op);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom), randAddrs[$urandom_range(0, 11)], 16'($urandom), rd, op);
    end

    applyStimulus(1'b1, 16'h0020, 16'h1111, rd, op);
    applyStimulus(1'b1, 16'hFFFF, 16'h4321, rd, op);
    applyStimulus(1'b0, 16'h0010, 16'h0000, rd, op);
    memWE = 1'b1; memAddr = 16'h0020; memWrite = 16'h5555; memReq = 1'b1;
    @(negedge clk);
    memReq = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midRst.ready", {15'd0, memReady}, 16'd0);
    checkOutput("midRst.read", memRead, 16'h0000);
    checkOutput("midRst.out", outPort, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    relTime  = $time;
    outModel = 16'h0000;
    lastRead = 16'h0000;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (memReady) seen++;
    end
    checkOutput("midRst.noReady", 16'(seen), 16'd0);
    applyStimulus(1'b0, 16'h0020, 16'h0000, rd, op);
    checkOutput("midRst.ramKept", rd, 16'h1111);

    applyStimulus0(1'b1, 16'h0033, 16'h7E7E, 16'h0000, 16'h0000);
    applyStimulus0(1'b0, 16'h0033, 16'h0000, 16'h7E7E, 16'h0000);
    applyStimulus0(1'b1, 16'hFFFF, 16'h1357, 16'h7E7E, 16'h1357);
    applyStimulus0(1'b0, 16'hFFFE, 16'h0000, 16'(edgesSinceRelease()), 16'h1357);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
